// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle control sequencer for a simple accumulator datapath
//
// Purpose: walks each instruction through FETCH, DECODE, EXEC1 and, for movb/movc
// only, EXEC2, and drives the datapath strobes for the decoded operation.
// Optional feature macro: CTRL_SEQ_ILLEGAL_TRAP_EN. When it is defined, a DECODE cycle
// with no instruction line high traps to HALT and sets a sticky illegal flag. When it
// is undefined, that case behaves as nop and illegal is tied low.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   run                             level enable, sampled in IDLE and after the last EXEC
//   mova .. halt                    one-hot decoded-instruction lines
//   z, c                            ALU flags, used by jz/jc in EXEC1
//   dec_en                          decoder enable (DECODE)
//   ir_ld, pc_inc, pc_ld, mem_rd,
//   mem_wr, reg_we, in_en, out_en   datapath strobes
//   alu_op                          ALU function select
//   halted, illegal, state          status and debug outputs
module ctrl_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mova,
    input  logic       movb,
    input  logic       movc,
    input  logic       add,
    input  logic       sub,
    input  logic       and1,
    input  logic       not1,
    input  logic       rsr,
    input  logic       rsl,
    input  logic       jmp,
    input  logic       jz,
    input  logic       jc,
    input  logic       in1,
    input  logic       out1,
    input  logic       nop,
    input  logic       halt,
    input  logic       z,
    input  logic       c,
    output logic       dec_en,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       in_en,
    output logic       out_en,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC1  = 3'd3;
    localparam logic [2:0] S_EXEC2  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    // Bit positions of the instruction lines; lower index wins when several are high.
    localparam int OP_MOVA = 0;
    localparam int OP_MOVB = 1;
    localparam int OP_MOVC = 2;
    localparam int OP_ADD  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_NOT  = 6;
    localparam int OP_RSR  = 7;
    localparam int OP_RSL  = 8;
    localparam int OP_JMP  = 9;
    localparam int OP_JZ   = 10;
    localparam int OP_JC   = 11;
    localparam int OP_IN   = 12;
    localparam int OP_OUT  = 13;
    localparam int OP_NOP  = 14;
    localparam int OP_HALT = 15;

    logic [2:0]  state_q, state_d;
    logic [15:0] op_q, op_d;
    logic [15:0] lines;
    logic [15:0] op_sel;
    logic        no_line;
    logic        unused_op_bits;

    assign lines = {halt, nop, out1, in1, jc, jz, jmp, rsl, rsr,
                    not1, and1, sub, add, movc, movb, mova};

    // Keep only the lowest set bit, which is the highest-priority instruction.
    assign op_sel  = lines & (~lines + 16'd1);
    assign no_line = (lines == 16'd0);

    // The op register is loaded only at the end of DECODE. An all-zero value means
    // "no operation" and produces no strobes in EXEC1.
    assign op_d = (state_q == S_DECODE) ? op_sel : op_q;

    // nop and halt never drive a strobe from the op register.
    assign unused_op_bits = ^{op_q[OP_NOP], op_q[OP_HALT]};

    // State and op register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // The flag is sticky: only rst clears it.
    assign illegal_d = illegal_q | ((state_q == S_DECODE) & no_line);

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (no_line) begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_EXEC1;
`endif
                end else if (op_sel[OP_HALT]) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (op_q[OP_MOVB] | op_q[OP_MOVC]) begin
                    state_d = S_EXEC2;
                end else begin
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC2:  state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic. Everything is a function of state_q and op_q, except pc_ld for
    // jz/jc, which follows the live flag inputs during EXEC1.
    always_comb begin
        dec_en = 1'b0;
        ir_ld  = 1'b0;
        pc_inc = 1'b0;
        pc_ld  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        reg_we = 1'b0;
        in_en  = 1'b0;
        out_en = 1'b0;
        alu_op = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_DECODE: dec_en = 1'b1;
            S_EXEC1: begin
                if (op_q[OP_MOVA]) reg_we = 1'b1;
                if (op_q[OP_MOVC]) mem_rd = 1'b1;
                if (op_q[OP_ADD]) begin reg_we = 1'b1; alu_op = 3'b001; end
                if (op_q[OP_SUB]) begin reg_we = 1'b1; alu_op = 3'b010; end
                if (op_q[OP_AND]) begin reg_we = 1'b1; alu_op = 3'b011; end
                if (op_q[OP_NOT]) begin reg_we = 1'b1; alu_op = 3'b100; end
                if (op_q[OP_RSR]) begin reg_we = 1'b1; alu_op = 3'b101; end
                if (op_q[OP_RSL]) begin reg_we = 1'b1; alu_op = 3'b110; end
                pc_ld = op_q[OP_JMP] | (op_q[OP_JZ] & z) | (op_q[OP_JC] & c);
                if (op_q[OP_IN]) begin in_en = 1'b1; reg_we = 1'b1; end
                if (op_q[OP_OUT]) out_en = 1'b1;
            end
            S_EXEC2: begin
                reg_we = op_q[OP_MOVC];
                mem_wr = op_q[OP_MOVB];
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT);
    assign state  = state_q;

endmodule
